seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed seven-segment scan driver that sits directly downstream of the calculator's `display_segments_o`. It holds one byte per digit for the whole frame, latching a shadow copy once per frame so the display never tears. It drives one digit at a time onto shared active-low cathode lines and active-low anode selects. Each digit slot has anti-ghosting blanking and 4-bit PWM brightness.

## Interface
- `NumDigits`, 8, digits scanned; must be ≥1.
- `DigitCycles`, 1000, clock cycles per digit slot; must be > `BlankCycles`.
- `BlankCycles`, 16, cycles at the start of each slot with all anodes and cathodes off; must be ≥1.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `segments_i`  in  8*NumDigits  digit k = bits [8k+7:8k]; bit0=a … bit6=g, bit7=dp; 1 = lit.
- `enable_i`  in  1  0 forces display dark; the scan keeps running.
- `brightness_i`  in  4  0 = dark, 15 = full on.
- `anodes_o`  out  NumDigits  active-low digit select; at most one bit low.
- `cathodes_o`  out  8  active-low segments, same bit order as `segments_i`.
- `frame_o`  out  1  high for the single cycle in which the shadow is loaded.

## Operation
- Slot counter `c` runs 0..DigitCycles-1, width $clog2(DigitCycles). It increments every cycle and wraps to 0.
- Digit index `d` runs 0..NumDigits-1. It advances when `c` wraps, and wraps from NumDigits-1 to 0. Digit 0 (LSB byte) is scanned first.
- Phase is derived from `c`:
  - BLANK while `c` < BlankCycles.
  - DRIVE otherwise.
- Shadow register, 8*NumDigits bits:
  - Loads `segments_i` in the cycle where `c`==0 and `d`==0.
  - Holds its value at all other times.
  - `frame_o` = (`c`==0 && `d`==0).
- PWM:
  - `p` = (`c` − BlankCycles)[3:0].
  - `lit` = DRIVE && `enable_i` && (`brightness_i`==15 || `p` < `brightness_i`).
- Outputs are registered, computed from the current `c`, `d`, shadow and inputs:
  - `anodes_o` = lit ? ~(1<<d) : all ones.
  - `cathodes_o` = lit ? ~shadow[8d+7:8d] : 8'hFF.
- Anodes and cathodes are never active during BLANK. No two anodes are ever low in the same cycle.

## Timing
- Reset values (asynchronous, immediate):
  - `anodes_o` all ones, `cathodes_o` 8'hFF, `frame_o` 0.
  - `c`=0, `d`=0, shadow 0.
- First clock after reset release: `frame_o` is high, and the shadow captures `segments_i`.
- Output latency: one cycle. The registered output for slot position `c` is visible in the cycle after `c` is current.
  - First drive cycle of a slot therefore appears at `c`==BlankCycles+1.
  - The last drive cycle spills into `c`==0 of the next slot. The BLANK length still guarantees separation.
- Frame period: NumDigits*DigitCycles cycles. `frame_o` pulses exactly once per frame.
- `segments_i` changes mid-frame have no effect until the next `frame_o`.
- `brightness_i` and `enable_i` are sampled every cycle, with effect one cycle later.
- `brightness_i`=0 gives no lit cycles; 15 gives all drive cycles lit.
- Reset mid-scan: outputs go dark immediately, and the scan restarts at digit 0 with a fresh shadow load.

## Structure
- `calc_pkg` gains:
  - `seg_t`, an 8-bit packed segment byte.
  - Constants `SEG_OFF` = 8'hFF (active-low all off) and `BRIGHT_FULL` = 4'hF.
- One sub-module, `scan_timer`:
  - Owns `c`, `d`, phase and `frame_o`.
  - Parameterized by NumDigits, DigitCycles and BlankCycles.
- The top module holds the shadow register, the PWM compare and the output registers.

## Test plan
All scenarios use NumDigits=4, DigitCycles=8, BlankCycles=2.

- **Reset:** assert `rst_i` asynchronously mid-cycle → `anodes_o`=4'hF and `cathodes_o`=8'hFF immediately. After release, `frame_o`=1 on the first clock.
- **Basic scan:** `segments_i`=32'h3F06_5B4F, brightness 15, enable 1.
  - Digits are driven in order 0..3.
  - Digit 0: `anodes_o`=4'b1110, `cathodes_o`=8'hB0, for 6 of every 8 cycles.
  - The 2 blank cycles show 4'hF / 8'hFF.
  - Frame period is 32 cycles.
- **No tearing:** change `segments_i` to 0 during digit 2 → digits 2–3 still show the old values; zeros appear only after the next `frame_o`.
- **Brightness:**
  - 0 → anodes never low.
  - 3 → digit 0 lit for exactly 3 of 6 drive cycles (`p`=0,1,2).
  - 15 → 6 of 6.
- **Enable:** `enable_i`=0 for one full frame → all outputs dark, while `frame_o` still pulses every 32 cycles.
- **One-hot check:** random `segments_i`, brightness and enable over 1000 frames → assert at most one `anodes_o` bit low every cycle, and none low while `c`∈{1,2}.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

  // One seven-segment digit: bit0=a .. bit6=g, bit7=dp.
  typedef logic [7:0] seg_t;

  // Active-low "everything off" pattern for the cathode lines.
  localparam seg_t SEG_OFF = 8'hFF;

  // Brightness code that keeps every drive cycle lit.
  localparam logic [3:0] BRIGHT_FULL = 4'hF;

  // Position within a digit slot: dark guard interval, then drive window.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Slot and digit sequencing for the scan driver: slot counter, digit index,
// blank/drive phase and the once-per-frame pulse.
module scan_timer
  import calc_pkg::*;
#(
  parameter int NumDigits   = 8,
  parameter int DigitCycles = 1000,
  parameter int BlankCycles = 16,
  localparam int CntW = $clog2(DigitCycles),
  localparam int DigW = (NumDigits > 1) ? $clog2(NumDigits) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [CntW-1:0] cnt_o,
  output logic [DigW-1:0] digit_o,
  output logic            drive_o,
  output logic            load_o,
  output logic            frame_o
);

  localparam logic [CntW-1:0] CntLast  = CntW'(DigitCycles - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BlankCycles);
  localparam logic [DigW-1:0] DigLast  = DigW'(NumDigits - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DigW-1:0] digit_q, digit_d;
  logic            frame_q;
  logic            frameStart;
  phase_e          phase;

  // Advance the slot counter every cycle; the digit index steps on slot wrap.
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    digit_d = digit_q;
    if (cnt_q == CntLast) begin
      cnt_d   = '0;
      digit_d = (digit_q == DigLast) ? '0 : digit_q + DigW'(1);
    end
  end

  // Phase and frame start are pure functions of the current position.
  always_comb begin
    phase      = (cnt_q < CntBlank) ? PH_BLANK : PH_DRIVE;
    frameStart = (cnt_q == '0) && (digit_q == '0);
  end

  // Position registers plus the registered frame pulse (dark on reset).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      digit_q <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      frame_q <= frameStart;
    end
  end

  assign cnt_o   = cnt_q;
  assign digit_o = digit_q;
  assign drive_o = (phase == PH_DRIVE);
  assign load_o  = frameStart;
  assign frame_o = frame_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-frame shadow copy,
// anti-ghosting blank interval and 4-bit PWM brightness.
module seg_scan_driver
  import calc_pkg::*;
#(
  parameter int NumDigits   = 8,
  parameter int DigitCycles = 1000,
  parameter int BlankCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [8*NumDigits-1:0] segments_i,
  input  logic                   enable_i,
  input  logic [3:0]             brightness_i,
  output logic [NumDigits-1:0]   anodes_o,
  output logic [7:0]             cathodes_o,
  output logic                   frame_o
);

  localparam int CntW = $clog2(DigitCycles);
  localparam int DigW = (NumDigits > 1) ? $clog2(NumDigits) : 1;

  logic [CntW-1:0]        cnt;
  logic [DigW-1:0]        digit;
  logic                   drive;
  logic                   load;

  seg_t [NumDigits-1:0]   shadow_q, shadow_d;
  logic [NumDigits-1:0]   anodes_q, anodes_d;
  seg_t                   cathodes_q, cathodes_d;
  logic [3:0]             pwmPhase;
  logic                   lit;

  scan_timer #(
    .NumDigits  (NumDigits),
    .DigitCycles(DigitCycles),
    .BlankCycles(BlankCycles)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cnt_o  (cnt),
    .digit_o(digit),
    .drive_o(drive),
    .load_o (load),
    .frame_o(frame_o)
  );

  // Shadow copy only refreshes at frame start so a frame never tears.
  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d = segments_i;
    end
  end

  // PWM compare and next output pattern; only the current digit may be lit.
  always_comb begin
    pwmPhase   = 4'(32'(cnt) - 32'(BlankCycles));
    lit        = drive && enable_i &&
                 ((brightness_i == BRIGHT_FULL) || (pwmPhase < brightness_i));
    anodes_d   = '1;
    cathodes_d = SEG_OFF;
    if (lit) begin
      anodes_d[digit] = 1'b0;
      cathodes_d      = ~shadow_q[digit];
    end
  end

  // Shadow and output registers; reset forces the display dark at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q   <= '0;
      anodes_q   <= '1;
      cathodes_q <= SEG_OFF;
    end else begin
      shadow_q   <= shadow_d;
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign anodes_o   = anodes_q;
  assign cathodes_o = cathodes_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level reference model predicts
// every output cycle, a monitor compares, and directed scenarios add counts.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg = '0;
  logic        en  = 1'b0;
  logic [3:0]  br  = '0;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic        frame;

  typedef struct {
    logic [3:0] an;
    logic [7:0] cat;
    logic       fr;
    int         slotPos;
  } exp_t;

  exp_t        expQ[$];
  exp_t        modelExp;
  exp_t        monExp;
  int          testsRun    = 0;
  int          testsFailed = 0;
  int          tick        = 0;
  logic [31:0] frameData   = '0;
  int          mPos, mSlot, mDigit, mPwm;
  logic        mLit;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NumDigits  (ND),
    .DigitCycles(DC),
    .BlankCycles(BC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .segments_i  (seg),
    .enable_i    (en),
    .brightness_i(br),
    .anodes_o    (anodes),
    .cathodes_o  (cathodes),
    .frame_o     (frame)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [3:0] b, input logic e);
    @(negedge clk);
    seg = s;
    br  = b;
    en  = e;
  endtask

  // Counts cycles over one frame whose outputs equal the given pattern.
  task automatic countMatch(input logic [3:0] an, input logic [7:0] cat, output int n);
    n = 0;
    repeat (FRAME) begin
      @(posedge clk);
      #2;
      if (anodes == an && cathodes == cat) n++;
    end
  endtask

  // Counts cycles over one frame in which any anode is driven.
  task automatic countAnyLit(output int n);
    n = 0;
    repeat (FRAME) begin
      @(posedge clk);
      #2;
      if (anodes != 4'hF) n++;
    end
  endtask

  task automatic measureFramePeriod(output int period);
    int w;
    w = 0;
    period = -1;
    while (frame !== 1'b1 && w < 100) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (frame !== 1'b1) return;
    w = 0;
    do begin
      @(posedge clk);
      #2;
      w++;
    end while (frame !== 1'b1 && w < 100);
    if (frame === 1'b1) period = w;
  endtask

  // Reference model: position follows from the edge count since reset, the
  // frame image is whatever segments were present at each frame start.
  always @(posedge clk) begin
    if (!rst) begin
      mPos   = tick % FRAME;
      mSlot  = mPos % DC;
      mDigit = mPos / DC;
      if (mPos == 0) frameData = seg;
      mPwm = mSlot - BC;
      mLit = (mSlot >= BC) && en && (br == 4'd15 || mPwm < int'(br));
      modelExp.fr      = (mPos == 0);
      modelExp.an      = mLit ? ~(4'b0001 << mDigit) : 4'hF;
      modelExp.cat     = mLit ? ~frameData[8*mDigit +: 8] : 8'hFF;
      modelExp.slotPos = mSlot;
      expQ.push_back(modelExp);
      tick++;
    end
  end

  // Monitor: every registered output cycle is popped and compared.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("anodes", 32'(anodes), 32'(monExp.an));
      checkOutput("cathodes", 32'(cathodes), 32'(monExp.cat));
      checkOutput("frame", 32'(frame), 32'(monExp.fr));
      checkOutput("oneHot", 32'($countones(~anodes) <= 1), 32'd1);
      if (monExp.slotPos < BC) checkOutput("blankDark", 32'(anodes), 32'hF);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int w;

    // Reset state while reset is held from time zero.
    #12;
    checkOutput("resetAnodes", 32'(anodes), 32'hF);
    checkOutput("resetCathodes", 32'(cathodes), 32'hFF);
    checkOutput("resetFrame", 32'(frame), 32'd0);

    // Basic scan.
    applyStimulus(32'h3F06_5B4F, 4'd15, 1'b1);
    tick = 0;
    rst  = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("frameAfterRelease", 32'(frame), 32'd1);
    repeat (40) @(posedge clk);
    countMatch(4'b1110, 8'hB0, n);
    checkOutput("digit0LitCycles", n, 6);
    measureFramePeriod(n);
    checkOutput("framePeriod", n, FRAME);

    // No tearing: change segments during digit 2.
    applyStimulus(32'hC0FF_EE12, 4'd15, 1'b1);
    repeat (40) @(posedge clk);
    w = 0;
    while (frame !== 1'b1 && w < 100) begin
      @(posedge clk);
      #2;
      w++;
    end
    repeat (18) @(posedge clk);
    applyStimulus(32'h0, 4'd15, 1'b1);
    w = 0;
    do begin
      @(posedge clk);
      #2;
      w++;
    end while (anodes != 4'b0111 && w < 20);
    checkOutput("digit3OldValue", 32'(cathodes), 32'h3F);
    repeat (40) @(posedge clk);
    countMatch(4'b0111, 8'hFF, n);
    checkOutput("digit3ZeroAfterFrame", n, 6);

    // Brightness sweep.
    applyStimulus(32'h3F06_5B4F, 4'd0, 1'b1);
    repeat (40) @(posedge clk);
    countAnyLit(n);
    checkOutput("bright0Lit", n, 0);
    applyStimulus(32'h3F06_5B4F, 4'd3, 1'b1);
    repeat (40) @(posedge clk);
    countMatch(4'b1110, 8'hB0, n);
    checkOutput("bright3Digit0", n, 3);
    applyStimulus(32'h3F06_5B4F, 4'd15, 1'b1);
    repeat (40) @(posedge clk);
    countMatch(4'b1110, 8'hB0, n);
    checkOutput("bright15Digit0", n, 6);

    // Enable low keeps the display dark but the frame keeps ticking.
    applyStimulus(32'h3F06_5B4F, 4'd15, 1'b0);
    repeat (2) @(posedge clk);
    countAnyLit(n);
    checkOutput("disabledLit", n, 0);
    measureFramePeriod(n);
    checkOutput("disabledFramePeriod", n, FRAME);

    // Asynchronous reset mid-scan while a digit is lit.
    applyStimulus(32'h3F06_5B4F, 4'd15, 1'b1);
    w = 0;
    do begin
      @(posedge clk);
      #3;
      w++;
    end while (anodes == 4'hF && w < 40);
    checkOutput("litBeforeReset", 32'(anodes != 4'hF), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midResetAnodes", 32'(anodes), 32'hF);
    checkOutput("midResetCathodes", 32'(cathodes), 32'hFF);
    checkOutput("midResetFrame", 32'(frame), 32'd0);
    expQ.delete();
    tick = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("frameAfterMidReset", 32'(frame), 32'd1);

    // Randomized run over many frames, inputs changing at random points.
    applyStimulus($urandom, 4'($urandom_range(15)), 1'b1);
    for (int i = 0; i < 1000 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) seg = $urandom;
      if ($urandom_range(15) == 0) br = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) en = ($urandom_range(3) != 0);
    end

    repeat (2) @(posedge clk);
    #3;
    checkOutput("queueDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
